// File: rtl/ysyx_24110015_if_id_queue.sv
// Instruction queue between IFU and IDU: buffers {pc, inst, err} tuples
// with valid/ready handshakes and a one-cycle flush on redirect.
//
// Ports:
//   clk, rst (async, active-low), flush   - clock, reset, redirect
//   in_valid/in_ready, in_pc/in_inst/in_err       - push side (IFU)
//   out_valid/out_ready, out_pc/out_inst/out_err  - pop side (IDU)
//   count                                         - current occupancy
module ysyx_24110015_if_id_queue #(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int IW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [AW-1:0]            in_pc,
    input  logic [IW-1:0]            in_inst,
    input  logic                     in_err,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [AW-1:0]            out_pc,
    output logic [IW-1:0]            out_inst,
    output logic                     out_err,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + IW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign {out_pc, out_inst, out_err} = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {in_pc, in_inst, in_err};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    logic [PW-1:0] ptr_diff;
    assign ptr_diff = wr_ptr_q - rd_ptr_q;

    a_no_push_full : assert property (
        @(posedge clk) disable iff (!rst) push |-> (count_q != FULL));
    a_no_pop_empty : assert property (
        @(posedge clk) disable iff (!rst) pop |-> (count_q != '0));
    a_count_ptrs : assert property (
        @(posedge clk) disable iff (!rst)
        (count_q == {1'b0, ptr_diff}) ||
        ((count_q == FULL) && (ptr_diff == '0)));

endmodule

// File: doc/ysyx_24110015_if_id_queue.md
Name: ysyx_24110015_if_id_queue

Overview:
- Instruction queue between the fetch unit (IFU) and the decode unit (IDU).
- Buffers fetched {pc, inst, err} tuples so fetch and decode are decoupled by valid/ready handshakes.
- Fetch can run ahead of decode by up to DEPTH instructions.
- Control can drop all buffered instructions in one cycle on a redirect (branch, jump or trap).

Parameters:
- DEPTH, 2, number of entries; must be a power of two and at least 2.
- AW, 32, width of pc.
- IW, 32, width of inst.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low: the queue is cleared while rst is 0.
- flush  input  1  redirect from controller/WBU; discards all entries.
- in_valid  input  1  IFU has a fetched instruction (IFU control_iMemRead_end).
- in_pc  input  AW  pc of the fetched instruction.
- in_inst  input  IW  fetched instruction word.
- in_err  input  1  fetch bus error (rresp != 0).
- in_ready  output  1  queue accepts a push this cycle.
- out_valid  output  1  head entry is valid for the IDU.
- out_pc  output  AW  pc of the head entry.
- out_inst  output  IW  instruction of the head entry.
- out_err  output  1  error flag of the head entry.
- out_ready  input  1  IDU consumes the head entry this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage:
  - Circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - A separate occupancy counter, count, runs from 0 to DEPTH.
- Handshake rules:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
- Ready and valid:
  - in_ready = (count != DEPTH). It is registered-state derived only and does not depend on out_ready in the same cycle, so a full queue never accepts a push.
  - out_valid = (count != 0). out_pc, out_inst and out_err come from the entry at rd_ptr.
- Latency:
  - A push into an empty queue becomes visible on out_* in the cycle after the accepting edge. There is no combinational bypass.
- Per-edge update when rst=1:
  - flush=1: rd_ptr=0, wr_ptr=0, count=0. Any push or pop in the same cycle is ignored. Storage contents are don't-care.
  - push only: mem[wr_ptr] <= {in_pc, in_inst, in_err}; wr_ptr+1; count+1.
  - pop only: rd_ptr+1; count-1.
  - push and pop together (legal only when 0<count<DEPTH): write the entry, advance both pointers, count unchanged.
- Wrap-around: a pointer at DEPTH-1 advances to 0.
- Stability: out_* stay stable while out_valid=1 and out_ready=0. Upstream must likewise hold in_* stable while in_valid=1 and in_ready=0.
- Reset:
  - Asserting rst (0) at any time, including mid-transfer, immediately forces count=0, out_valid=0, in_ready=1 and both pointers to 0.
  - The data outputs reset to 0: out_pc=0, out_inst=0, out_err=0. Head storage is cleared to 0 on reset so these values hold.
  - After rst deasserts, the first push is accepted on the next rising edge.
- Error entries: an entry with err=1 is queued and delivered exactly like a normal entry. The IDU decides how to trap.
- Assertions (simulation only):
  - No push when count==DEPTH.
  - No pop when count==0.
  - count equals (wr_ptr-rd_ptr) mod DEPTH, or DEPTH when the pointers are equal and the queue is full.

Test Plan:
- Reset, then one push of pc=0x80000000, inst=0x00000413 with out_ready=0 -> out_valid=1 next cycle with the same values, count=1; out_ready=1 for one cycle -> out_valid=0, count=0.
- DEPTH=2, push pc 0x80000000 and then 0x80000004 with out_ready=0 -> count=2, in_ready=0; third in_valid held -> not accepted until a pop; pops return the entries in order, then the held 0x80000008.
- Continuous streaming with in_valid=1 and out_ready=1 for 10 cycles of pc 0x80000000+4k -> every pc delivered once, in order; pointers wrap at least twice; count stays at 1 in steady state.
- Queue holding 2 entries, flush=1 together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; neither the pushed nor the popped entry is observed.
- Push with in_err=1, pc=0x00000000 -> out_err=1 delivered with that pc; the following normal entry has out_err=0.
- rst driven low asynchronously mid-cycle with 1 entry queued -> out_valid=0, count=0 immediately (before the next edge); after release, a push of pc=0x80000010 is the only entry delivered.
